// File: rtl/fanout_bcast_ctrl_pkg.sv
// Shared types and constants for the broadcast fork controller.
package fanout_bcast_ctrl_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fork_state_t;

  localparam int STALL_W = 16;
  localparam int DST_MAX = 16;

endpackage

// File: rtl/fanout_stall_counter.sv
// Saturating up-counter with synchronous clear; one cycle from inc to cnt, no backpressure.
module fanout_stall_counter
  import fanout_bcast_ctrl_pkg::*;
#(
  parameter int W = STALL_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fanout_bcast_ctrl.sv
// Eager one-entry broadcast fork: token visible one cycle after acceptance, each enabled
// destination takes it independently; upstream stalls until every pending destination is served.
module fanout_bcast_ctrl
  import fanout_bcast_ctrl_pkg::*;
#(
  parameter int NUM_DST = 9,
  parameter int DATA_W  = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DST-1:0] cfg_dst_en,
  input  logic               src_valid,
  input  logic [DATA_W-1:0]  src_data,
  output logic               src_ready,
  output logic [NUM_DST-1:0] dst_valid,
  output logic [DATA_W-1:0]  dst_data,
  input  logic [NUM_DST-1:0] dst_ready,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  fork_state_t        state;
  logic [DATA_W-1:0]  tok_buf;
  logic [NUM_DST-1:0] act_mask;
  logic [NUM_DST-1:0] served;
  logic [NUM_DST-1:0] pending;
  logic               full;
  logic               done_now;
  logic               load;

  assign full     = (state == FULL);
  assign pending  = act_mask & ~served;
  // dst_valid comes from registers only, so destinations may wait on valid before raising ready.
  assign dst_valid = full ? pending : '0;
  assign dst_data  = tok_buf;
  assign done_now  = full && ((pending & ~dst_ready) == '0);
  assign src_ready = !full || done_now;
  assign load      = src_valid && src_ready;
  assign busy      = full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      tok_buf  <= '0;
      act_mask <= '0;
      served   <= '0;
    end else if (load) begin
      tok_buf  <= src_data;
      act_mask <= cfg_dst_en;
      served   <= '0;
      // An all-zero mask has no consumers, so the token is dropped on arrival.
      state    <= (cfg_dst_en != '0) ? FULL : EMPTY;
    end else if (done_now) begin
      state <= EMPTY;
    end else if (full) begin
      served <= served | (pending & dst_ready);
    end
  end

  fanout_stall_counter #(
    .W(STALL_W)
  ) u_stall_counter (
    .clk(clk),
    .clr(rst),
    .inc(full && !done_now),
    .cnt(stall_cnt)
  );

endmodule
